// File: rtl/click_classifier_pkg.sv
// ---------------------------------------------------------------------------
// click_pkg
// Shared definitions for the click classifier and any other block that needs
// to turn a time window into a cycle count.
//   state_e     : burst-tracking FSM states (IDLE, COLLECT)
//   win_cycles  : clock frequency in MHz times window in microseconds gives
//                 the window length in clock cycles
// ---------------------------------------------------------------------------
package click_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_e;

   // MHz * us cancels to a plain cycle count, so no rounding is involved.
   function automatic int win_cycles(input int freq_mhz, input int window_us);
      return freq_mhz * window_us;
   endfunction

endpackage

// File: rtl/click_classifier.sv
// ---------------------------------------------------------------------------
// click_classifier
// Groups debounced key-press strobes into bursts. A burst ends when a full
// window of W cycles passes with no further press. It is then reported once
// as a click count, saturated at MAX_CLICKS, together with an overflow flag.
//
// Ports:
//   clk_i              single clock, rising edge
//   rst_i              asynchronous, active-high reset
//   key_pressed_stb_i  one-cycle press strobe, already synchronous to clk_i
//   click_valid_o      one-cycle pulse when a finished burst is reported
//   click_cnt_o        presses in the reported burst (saturated); held
//                      until the next report
//   click_ovf_o        reported burst had more than MAX_CLICKS presses;
//                      held until the next report
//   busy_o             a burst is being collected
// ---------------------------------------------------------------------------
module click_classifier
   import click_pkg::*;
#(
   parameter int CLK_FREQ_MHZ = 150,
   parameter int WINDOW_US    = 250,
   parameter int MAX_CLICKS   = 3,
   localparam int W  = win_cycles(CLK_FREQ_MHZ, WINDOW_US),
   localparam int CW = $clog2(MAX_CLICKS + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          key_pressed_stb_i,
   output logic          click_valid_o,
   output logic [CW-1:0] click_cnt_o,
   output logic          click_ovf_o,
   output logic          busy_o
);

   // The guard keeps the width legal long enough for the check below to
   // report a too-short window.
   localparam int TW = (W > 1) ? $clog2(W) : 1;

   localparam logic [TW-1:0] TIMER_LAST = TW'(W - 1);
   localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_CLICKS);

   // The window must span at least two cycles. Otherwise the timer has no
   // room to count between a press and the expiry edge.
   generate
      if (W < 2) begin : g_window_too_short
         $error("click_classifier: window must be at least 2 clock cycles");
      end
   endgenerate

   state_e          state;
   logic [TW-1:0]   timer;
   logic [CW-1:0]   count;
   logic            ovf_flag;

   // The whole burst tracker is a single registered process.
   //
   // - The timer counts idle cycles since the most recent press.
   // - Reaching W-1 with no press on the next edge closes the burst.
   // - A press on that same edge takes priority: it is counted and the
   //   window restarts, so no report is issued on that edge.
   // - The count saturates instead of wrapping. Presses beyond MAX_CLICKS
   //   only set the overflow flag.
   // - The report outputs are loaded only at expiry, so they keep the last
   //   result while the valid pulse is low.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= IDLE;
         timer         <= '0;
         count         <= '0;
         ovf_flag      <= 1'b0;
         click_valid_o <= 1'b0;
         click_cnt_o   <= '0;
         click_ovf_o   <= 1'b0;
         busy_o        <= 1'b0;
      end else begin
         click_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (key_pressed_stb_i) begin
                  count    <= CW'(1);
                  ovf_flag <= 1'b0;
                  timer    <= '0;
                  state    <= COLLECT;
                  busy_o   <= 1'b1;
               end
            end
            COLLECT: begin
               if (key_pressed_stb_i) begin
                  timer <= '0;
                  if (count < CNT_MAX) begin
                     count <= count + CW'(1);
                  end else begin
                     ovf_flag <= 1'b1;
                  end
               end else if (timer != TIMER_LAST) begin
                  timer <= timer + TW'(1);
               end else begin
                  click_valid_o <= 1'b1;
                  click_cnt_o   <= count;
                  click_ovf_o   <= ovf_flag;
                  state         <= IDLE;
                  busy_o        <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_click_classifier.sv
// ---------------------------------------------------------------------------
// tb_click_classifier
// Scoreboard bench for click_classifier (W = 10 cycles, MAX_CLICKS = 3).
//
// The reference model works only with absolute edge numbers. A burst is the
// set of presses where each press falls no more than W edges after the
// previous one. The burst is reported at the edge lying exactly W after its
// last press, provided that edge carries no press. Expected reports are
// queued by the driver, and the monitor pops them whenever the DUT raises
// click_valid_o.
// ---------------------------------------------------------------------------
module tb_click_classifier;

   localparam int FREQ   = 1;
   localparam int WIN_US = 10;
   localparam int W      = FREQ * WIN_US;
   localparam int MAXC   = 3;
   localparam int CW     = $clog2(MAXC + 1);

   typedef struct {
      int edge_no;
      int cnt;
      int ovf;
   } report_t;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          key_pressed_stb_i = 1'b0;
   logic          click_valid_o;
   logic [CW-1:0] click_cnt_o;
   logic          click_ovf_o;
   logic          busy_o;

   int checks = 0;
   int errors = 0;
   int edge_count = 0;

   // Reference model state, expressed in edge numbers
   bit      model_active = 1'b0;
   int      last_press   = 0;
   int      press_count  = 0;
   int      hold_cnt     = 0;
   int      hold_ovf     = 0;
   report_t exp_q[$];

   click_classifier #(
      .CLK_FREQ_MHZ (FREQ),
      .WINDOW_US    (WIN_US),
      .MAX_CLICKS   (MAXC)
   ) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .key_pressed_stb_i (key_pressed_stb_i),
      .click_valid_o     (click_valid_o),
      .click_cnt_o       (click_cnt_o),
      .click_ovf_o       (click_ovf_o),
      .busy_o            (busy_o)
   );

   // Free-running clock: rising edges at 5, 15, 25, ...
   always #5 clk_i = ~clk_i;

   // Shared edge numbering for the driver and the monitor
   always @(posedge clk_i) edge_count++;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)",
                  name, actual, expected, edge_count);
      end
   endtask

   // Predict what happens at edge e, given whether a strobe is sampled there.
   function automatic void modelEdge(input int e, input bit stb);
      report_t r;
      if (model_active && !stb && (e == last_press + W)) begin
         r.edge_no = e;
         r.cnt     = (press_count > MAXC) ? MAXC : press_count;
         r.ovf     = (press_count > MAXC) ? 1 : 0;
         exp_q.push_back(r);
         hold_cnt     = r.cnt;
         hold_ovf     = r.ovf;
         model_active = 1'b0;
      end
      if (stb) begin
         if (model_active) begin
            press_count++;
         end else begin
            model_active = 1'b1;
            press_count  = 1;
         end
         last_press = e;
      end
   endfunction

   function automatic void modelReset();
      model_active = 1'b0;
      press_count  = 0;
      hold_cnt     = 0;
      hold_ovf     = 0;
      exp_q.delete();
   endfunction

   // Drive one cycle: the strobe is set on the falling edge and sampled on
   // the next rising edge. The model is updated for that edge.
   task automatic applyStimulus(input bit stb);
      @(negedge clk_i);
      key_pressed_stb_i = stb;
      modelEdge(edge_count + 1, stb);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0);
   endtask

   // Assert reset partway through a low clock phase. All outputs must clear
   // before any clock edge arrives.
   task automatic pulseReset();
      @(negedge clk_i);
      key_pressed_stb_i = 1'b0;
      #2;
      rst_i = 1'b1;
      modelReset();
      #1;
      checkOutput("rst_valid", int'(click_valid_o), 0);
      checkOutput("rst_cnt",   int'(click_cnt_o),   0);
      checkOutput("rst_ovf",   int'(click_ovf_o),   0);
      checkOutput("rst_busy",  int'(busy_o),        0);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // Monitor: after each rising edge, compare busy and the held report
   // values against the model. Each valid pulse is matched to the queue.
   always @(posedge clk_i) begin
      report_t r;
      #1;
      checkOutput("busy",     int'(busy_o),      (model_active && !rst_i) ? 1 : 0);
      checkOutput("hold_cnt", int'(click_cnt_o), hold_cnt);
      checkOutput("hold_ovf", int'(click_ovf_o), hold_ovf);
      if (click_valid_o) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_valid", 1, 0);
         end else begin
            r = exp_q.pop_front();
            checkOutput("report_edge", edge_count, r.edge_no);
            checkOutput("report_cnt",  int'(click_cnt_o), r.cnt);
            checkOutput("report_ovf",  int'(click_ovf_o), r.ovf);
         end
      end else if (exp_q.size() != 0 && exp_q[0].edge_no <= edge_count) begin
         r = exp_q.pop_front();
         checkOutput("missing_valid", 0, 1);
      end
   end

   initial begin
      $display("[TB] start");
      modelReset();
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      checkOutput("init_valid", int'(click_valid_o), 0);
      checkOutput("init_cnt",   int'(click_cnt_o),   0);
      checkOutput("init_ovf",   int'(click_ovf_o),   0);
      checkOutput("init_busy",  int'(busy_o),        0);

      // Single press
      applyStimulus(1'b1); idleCycles(14);
      // Two presses 7 apart
      applyStimulus(1'b1); idleCycles(6); applyStimulus(1'b1); idleCycles(14);
      // Second press lands exactly on the expiry edge
      applyStimulus(1'b1); idleCycles(9); applyStimulus(1'b1); idleCycles(14);
      // Five presses 3 apart: saturate and overflow, then a clean single
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1); idleCycles(2);
      end
      applyStimulus(1'b1); idleCycles(14);
      applyStimulus(1'b1); idleCycles(14);
      // Reset in the middle of a burst discards it
      applyStimulus(1'b1); idleCycles(2); applyStimulus(1'b1); idleCycles(1);
      pulseReset();
      idleCycles(3);
      applyStimulus(1'b1); idleCycles(14);
      // Press on the cycle right after a report starts a new burst
      applyStimulus(1'b1); idleCycles(10); applyStimulus(1'b1); idleCycles(14);

      // Random traffic with varying press density and occasional resets
      for (int blk = 0; blk < 24; blk++) begin
         int p;
         p = $urandom_range(4, 40);
         for (int i = 0; i < 100; i++) applyStimulus($urandom_range(0, 99) < p);
         if ($urandom_range(0, 3) == 0) pulseReset();
      end
      idleCycles(W + 5);
      checkOutput("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
